// File: rtl/baccarat_pkg.sv
// Shared types and codes for the baccarat round controller.
// Lights and results are both ordered {player, dealer}.
package baccarat_pkg;

    typedef enum logic [2:0] {
        ST_INIT   = 3'd0,
        ST_IDLE   = 3'd1,
        ST_CLEAR  = 3'd2,
        ST_PLAY   = 3'd3,
        ST_SETTLE = 3'd4,
        ST_HOLD   = 3'd5,
        ST_BROKE  = 3'd6
    } rc_state_t;

    localparam logic [1:0] BET_NONE   = 2'b00;
    localparam logic [1:0] BET_PLAYER = 2'b01;
    localparam logic [1:0] BET_DEALER = 2'b10;
    localparam logic [1:0] BET_TIE    = 2'b11;

    localparam logic [1:0] RES_NONE   = 2'b00;
    localparam logic [1:0] RES_PLAYER = 2'b10;
    localparam logic [1:0] RES_DEALER = 2'b01;
    localparam logic [1:0] RES_TIE    = 2'b11;

endpackage

// File: rtl/bet_settle.sv
// Combinational settlement: applies a round's outcome to the bankroll,
// saturating wins at the top of the bankroll range.
module bet_settle
    import baccarat_pkg::*;
#(
    parameter int BAL_W      = 12,
    parameter int TIE_PAYOUT = 8
) (
    input  logic [1:0]       side,
    input  logic [BAL_W-1:0] amount,
    input  logic [1:0]       lights,
    input  logic [BAL_W-1:0] balance,
    output logic [BAL_W-1:0] next_balance
);

    localparam int PW = $clog2(TIE_PAYOUT + 1);
    localparam int EW = BAL_W + PW + 1;

    function automatic logic [BAL_W-1:0] sat_bal(input logic [EW-1:0] sum);
        if (|sum[EW-1:BAL_W]) return {BAL_W{1'b1}};
        else                  return sum[BAL_W-1:0];
    endfunction

    logic          win;
    logic          lose;
    logic [EW-1:0] gain;

    always_comb begin
        win  = 1'b0;
        lose = 1'b0;
        gain = EW'(amount);
        case (side)
            BET_PLAYER: begin
                win  = (lights == RES_PLAYER);
                lose = (lights == RES_DEALER);
            end
            BET_DEALER: begin
                win  = (lights == RES_DEALER);
                lose = (lights == RES_PLAYER);
            end
            BET_TIE: begin
                if (lights == RES_TIE) begin
                    win  = 1'b1;
                    gain = EW'(amount) * EW'(TIE_PAYOUT);
                end else begin
                    lose = 1'b1;
                end
            end
            default: ;
        endcase

        next_balance = balance;
        if (win)       next_balance = sat_bal(EW'(balance) + gain);
        else if (lose) next_balance = balance - amount;
    end

endmodule

// File: rtl/dff.sv
// Parameterised register with asynchronous active-low reset.
module dff #(
    parameter int           W       = 1,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) q <= RST_VAL;
        else        q <= d;
    end

endmodule

// File: rtl/round_controller.sv
// Round-level controller: validates bets, pulses the game engine reset,
// waits for win lights (with timeout) and settles a saturating bankroll.
module round_controller
    import baccarat_pkg::*;
#(
    parameter int BAL_W        = 12,
    parameter int INIT_BALANCE = 1000,
    parameter int TIE_PAYOUT   = 8,
    parameter int TIMEOUT      = 15
) (
    input  logic             slow_clock,
    input  logic             resetb,
    input  logic             start,
    input  logic [1:0]       bet_side,
    input  logic [BAL_W-1:0] bet_amount,
    input  logic             player_win_light,
    input  logic             dealer_win_light,
    output logic             game_resetb,
    output logic             round_active,
    output logic [BAL_W-1:0] balance,
    output logic [7:0]       rounds_played,
    output logic [1:0]       result,
    output logic             bet_err,
    output logic             fault,
    output logic             bankrupt
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [2:0]       state_bits;
    rc_state_t        state;
    rc_state_t        state_next;
    logic [1:0]       side_q;
    logic [BAL_W-1:0] amount_q;
    logic [1:0]       lights_q;
    logic [CW-1:0]    cnt;
    logic [BAL_W-1:0] next_balance;
    logic             bet_ok;
    logic             light_seen;
    logic             timeout;

    dff #(.W(3), .RST_VAL(3'(ST_INIT))) u_state (
        .clk   (slow_clock),
        .rst_n (resetb),
        .d     (3'(state_next)),
        .q     (state_bits)
    );
    assign state = rc_state_t'(state_bits);

    bet_settle #(.BAL_W(BAL_W), .TIE_PAYOUT(TIE_PAYOUT)) u_settle (
        .side         (side_q),
        .amount       (amount_q),
        .lights       (lights_q),
        .balance      (balance),
        .next_balance (next_balance)
    );

    assign bet_ok     = (bet_side != BET_NONE) && (bet_amount != '0) && (bet_amount <= balance);
    assign light_seen = player_win_light || dealer_win_light;
    assign timeout    = (cnt == CW'(TIMEOUT - 1));

    always_comb begin
        state_next = state;
        case (state)
            ST_INIT, ST_IDLE: if (start && bet_ok) state_next = ST_CLEAR;
            ST_CLEAR:  state_next = ST_PLAY;
            ST_PLAY: begin
                if (light_seen)   state_next = ST_SETTLE;
                else if (timeout) state_next = ST_HOLD;
            end
            ST_SETTLE: state_next = (next_balance == '0) ? ST_BROKE : ST_HOLD;
            ST_HOLD:   if (!start) state_next = ST_IDLE;
            ST_BROKE:  state_next = ST_BROKE;
            default:   state_next = ST_INIT;
        endcase
    end

    // Control and bankroll state; game_resetb is registered from the next state
    always_ff @(posedge slow_clock or negedge resetb) begin
        if (!resetb) begin
            game_resetb   <= 1'b0;
            balance       <= BAL_W'(INIT_BALANCE);
            rounds_played <= '0;
            result        <= RES_NONE;
            bet_err       <= 1'b0;
            fault         <= 1'b0;
            cnt           <= '0;
        end else begin
            bet_err     <= 1'b0;
            game_resetb <= (state_next != ST_INIT) && (state_next != ST_CLEAR);
            case (state)
                ST_INIT, ST_IDLE: begin
                    if (start) begin
                        if (bet_ok) fault   <= 1'b0;
                        else        bet_err <= 1'b1;
                    end
                end
                ST_CLEAR: cnt <= '0;
                ST_PLAY: begin
                    if (!light_seen) begin
                        if (timeout) begin
                            fault  <= 1'b1;
                            result <= RES_NONE;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                ST_SETTLE: begin
                    balance       <= next_balance;
                    result        <= lights_q;
                    rounds_played <= rounds_played + 8'd1;
                end
                default: ;
            endcase
        end
    end

    // Latched bet and captured lights carry no reset; they are always written before use
    always_ff @(posedge slow_clock) begin
        if ((state == ST_INIT || state == ST_IDLE) && start && bet_ok) begin
            side_q   <= bet_side;
            amount_q <= bet_amount;
        end
        if (state == ST_PLAY && light_seen) lights_q <= {player_win_light, dealer_win_light};
    end

    assign round_active = (state == ST_CLEAR) || (state == ST_PLAY);
    assign bankrupt     = (state == ST_BROKE);

endmodule

// File: tb/tb_round_controller.sv
// Directed bench for round_controller: default-parameter instance plus a
// second instance with INIT_BALANCE 4000 for saturation and mid-round reset.
module tb_round_controller;

    logic        clk = 1'b0;
    logic        resetb, start, game_resetb, round_active, bet_err, fault, bankrupt;
    logic [1:0]  bet_side, lights, result;
    logic [11:0] bet_amount, balance;
    logic [7:0]  rounds_played;

    logic        s2_resetb, s2_start, s2_game_resetb, s2_round_active, s2_bet_err, s2_fault, s2_bankrupt;
    logic [1:0]  s2_side, s2_lights, s2_result;
    logic [11:0] s2_amount, s2_balance;
    logic [7:0]  s2_rounds;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    round_controller u_dut (
        .slow_clock       (clk),
        .resetb           (resetb),
        .start            (start),
        .bet_side         (bet_side),
        .bet_amount       (bet_amount),
        .player_win_light (lights[1]),
        .dealer_win_light (lights[0]),
        .game_resetb      (game_resetb),
        .round_active     (round_active),
        .balance          (balance),
        .rounds_played    (rounds_played),
        .result           (result),
        .bet_err          (bet_err),
        .fault            (fault),
        .bankrupt         (bankrupt)
    );

    round_controller #(.INIT_BALANCE(4000)) u_sat (
        .slow_clock       (clk),
        .resetb           (s2_resetb),
        .start            (s2_start),
        .bet_side         (s2_side),
        .bet_amount       (s2_amount),
        .player_win_light (s2_lights[1]),
        .dealer_win_light (s2_lights[0]),
        .game_resetb      (s2_game_resetb),
        .round_active     (s2_round_active),
        .balance          (s2_balance),
        .rounds_played    (s2_rounds),
        .result           (s2_result),
        .bet_err          (s2_bet_err),
        .fault            (s2_fault),
        .bankrupt         (s2_bankrupt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        resetb = 1'b0;
        start  = 1'b0;
        lights = 2'b00;
        tick();
        resetb = 1'b1;
    endtask

    // Plays one round; lights rise in PLAY cycle k. Leaves the DUT one edge past SETTLE.
    task automatic run_round(input logic [1:0] s, input logic [11:0] a, input logic [1:0] l, input int k);
        lights     = 2'b00;
        bet_side   = s;
        bet_amount = a;
        start      = 1'b1;
        tick();
        chk("clear_grb", game_resetb, 0);
        chk("clear_act", round_active, 1);
        tick();
        chk("play_grb", game_resetb, 1);
        for (int i = 1; i < k; i++) tick();
        lights = l;
        tick();
        chk("settle_act", round_active, 0);
        lights = 2'b00;
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        resetb = 1'b1; start = 1'b0; bet_side = 2'b00; bet_amount = '0; lights = 2'b00;
        s2_resetb = 1'b1; s2_start = 1'b0; s2_side = 2'b00; s2_amount = '0; s2_lights = 2'b00;
        #1;
        resetb = 1'b0; s2_resetb = 1'b0;
        #1;
        chk("rst_grb", game_resetb, 0);
        chk("rst_bal", balance, 1000);
        chk("rst_rounds", rounds_played, 0);
        chk("rst_result", result, 0);
        chk("rst_err", bet_err, 0);
        chk("rst_fault", fault, 0);
        chk("rst_bankrupt", bankrupt, 0);
        chk("rst_act", round_active, 0);
        chk("rst2_bal", s2_balance, 4000);
        tick();
        resetb = 1'b1; s2_resetb = 1'b1;
        tick();

        // Player bet 100, lights 10 in the 5th PLAY cycle
        run_round(2'b01, 12'd100, 2'b10, 5);
        chk("p_bal", balance, 1100);
        chk("p_rounds", rounds_played, 1);
        chk("p_result", result, 2'b10);
        tick(); tick();
        chk("hold_act", round_active, 0);
        chk("hold_bal", balance, 1100);
        start = 1'b0;
        tick();
        chk("idle_grb", game_resetb, 1);

        // Tie win pays 8x, then a dealer push on 11
        do_reset();
        run_round(2'b11, 12'd50, 2'b11, 3);
        chk("tie_bal", balance, 1400);
        chk("tie_result", result, 2'b11);
        start = 1'b0; tick();
        run_round(2'b10, 12'd50, 2'b11, 2);
        chk("push_bal", balance, 1400);
        chk("push_result", result, 2'b11);
        chk("push_rounds", rounds_played, 2);
        start = 1'b0; tick();

        // Rejected bets from IDLE
        bet_side = 2'b01; bet_amount = 12'd1401; start = 1'b1;
        tick();
        chk("over_err", bet_err, 1);
        chk("over_act", round_active, 0);
        chk("over_grb", game_resetb, 1);
        tick();
        chk("over_err_rep", bet_err, 1);
        bet_side = 2'b00; bet_amount = 12'd10;
        tick();
        chk("side_err", bet_err, 1);
        bet_side = 2'b01; bet_amount = 12'd0;
        tick();
        chk("zero_err", bet_err, 1);
        start = 1'b0;
        tick();
        chk("err_clear", bet_err, 0);

        // Timeout, then fault cleared by next accepted bet
        do_reset();
        bet_side = 2'b00; bet_amount = 12'd100; start = 1'b1;
        tick();
        chk("init_err", bet_err, 1);
        chk("init_grb", game_resetb, 0);
        bet_side = 2'b01;
        tick();
        tick();
        for (int i = 0; i < 14; i++) tick();
        chk("to_pre_fault", fault, 0);
        chk("to_pre_act", round_active, 1);
        tick();
        chk("to_fault", fault, 1);
        chk("to_act", round_active, 0);
        chk("to_bal", balance, 1000);
        chk("to_result", result, 0);
        start = 1'b0; tick();
        run_round(2'b01, 12'd100, 2'b01, 1);
        chk("fault_cleared", fault, 0);
        chk("loss_bal", balance, 900);
        chk("loss_result", result, 2'b01);
        start = 1'b0; tick();

        // Light arriving in the final PLAY cycle beats the timeout
        do_reset();
        run_round(2'b01, 12'd100, 2'b10, 15);
        chk("late_fault", fault, 0);
        chk("late_bal", balance, 1100);
        start = 1'b0; tick();

        // Bankruptcy is terminal
        do_reset();
        run_round(2'b10, 12'd1000, 2'b10, 2);
        chk("broke_bal", balance, 0);
        chk("broke_flag", bankrupt, 1);
        chk("broke_result", result, 2'b10);
        bet_side = 2'b01; bet_amount = 12'd1; start = 1'b1;
        tick(); tick();
        chk("broke_err", bet_err, 0);
        chk("broke_act", round_active, 0);
        chk("broke_stay", bankrupt, 1);
        start = 1'b0;

        // Round counter wraps 255 -> 0
        do_reset();
        for (int r = 0; r < 255; r++) begin
            run_round(2'b10, 12'd10, 2'b11, 1);
            start = 1'b0; tick();
        end
        chk("rounds_255", rounds_played, 255);
        run_round(2'b10, 12'd10, 2'b11, 1);
        chk("rounds_wrap", rounds_played, 0);
        chk("wrap_bal", balance, 1000);
        start = 1'b0; tick();

        // Saturating tie win on the 4000 instance, then async reset mid-PLAY
        s2_side = 2'b11; s2_amount = 12'd100; s2_start = 1'b1;
        tick();
        tick();
        s2_lights = 2'b11;
        tick();
        s2_lights = 2'b00;
        tick();
        chk("sat_bal", s2_balance, 4095);
        chk("sat_result", s2_result, 2'b11);
        s2_start = 1'b0; tick();
        s2_side = 2'b01; s2_start = 1'b1;
        tick();
        tick();
        chk("s2_play_act", s2_round_active, 1);
        tick();
        #2;
        s2_resetb = 1'b0;
        #1;
        chk("arst_grb", s2_game_resetb, 0);
        chk("arst_act", s2_round_active, 0);
        chk("arst_bal", s2_balance, 4000);
        chk("arst_rounds", s2_rounds, 0);
        chk("arst_result", s2_result, 0);
        chk("arst_fault", s2_fault, 0);
        chk("arst_bankrupt", s2_bankrupt, 0);
        chk("arst_err", s2_bet_err, 0);
        s2_start = 1'b0;
        tick();
        s2_resetb = 1'b1;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/round_controller.md
# round_controller

Round-level controller for the baccarat game engine. It accepts a bet (side and amount) and launches each round by pulsing the game state machine's active-low reset. It waits for the engine's win lights, settles a saturating bankroll, and counts rounds. The controller sits above the card-dealing state machine and owns that machine's reset input; the board's slow_clock and resetb drive the controller directly.

## Interface
- BAL_W, 12: bankroll width in bits.
- INIT_BALANCE, 1000: bankroll loaded on reset; must be < 2^BAL_W.
- TIE_PAYOUT, 8: multiplier paid on a winning tie bet.
- TIMEOUT, 15: slow_clock cycles allowed in PLAY before abort; must be ≥ 8.

Ports:
- slow_clock  in  1  sole clock, rising edge.
- resetb  in  1  reset, asynchronous, active-low.
- start  in  1  round request, level-sampled.
- bet_side  in  2  01 = player, 10 = dealer, 11 = tie, 00 = invalid.
- bet_amount  in  BAL_W  wager.
- player_win_light  in  1  from game state machine.
- dealer_win_light  in  1  from game state machine.
- game_resetb  out  1  active-low reset to the game state machine (registered).
- round_active  out  1  high in CLEAR and PLAY.
- balance  out  BAL_W  current bankroll.
- rounds_played  out  8  settled-round count.
- result  out  2  last outcome as {player, dealer} lights; 00 = none or aborted.
- bet_err  out  1  one-cycle pulse on a rejected bet.
- fault  out  1  sticky timeout flag; cleared on the next accepted bet.
- bankrupt  out  1  high in BROKE.

## Operation
- Reset values:
  - state = INIT
  - game_resetb = 0
  - balance = INIT_BALANCE
  - rounds_played = 0
  - result = 00
  - bet_err = 0, fault = 0, bankrupt = 0, round_active = 0
- States: INIT, IDLE, CLEAR, PLAY, SETTLE, HOLD, BROKE.
- INIT and IDLE accept a bet; they differ only in game_resetb (0 in INIT, so no unbetted round runs after power-up; 1 in IDLE, so the previous round's lights stay displayed).
- INIT/IDLE, start = 1:
  - Valid bet (bet_side ≠ 00, bet_amount ≠ 0, bet_amount ≤ balance): latch side and amount, clear fault, go to CLEAR.
  - Otherwise: pulse bet_err for one cycle and stay in the current state. The pulse repeats each cycle while start stays high with an invalid bet.
- CLEAR: game_resetb = 0 for exactly one cycle, then go to PLAY.
- PLAY:
  - game_resetb = 1. The timeout counter starts at 0 on entry and increments each cycle.
  - Either light = 1: capture both lights, go to SETTLE.
  - Counter reaches TIMEOUT with no light: set fault, set result = 00, leave balance unchanged, go to HOLD.
  - If a light and the timeout occur in the same cycle, the light wins.
- SETTLE (one cycle) updates balance:
  - Player bet: lights 10 → +amount; 01 → −amount; 11 → unchanged (push).
  - Dealer bet: lights 01 → +amount; 10 → −amount; 11 → unchanged.
  - Tie bet: lights 11 → +amount×TIE_PAYOUT; otherwise −amount.
  - Additions saturate at 2^BAL_W−1. Subtractions cannot underflow because of the bet check.
  - Also in SETTLE: result = captured lights; rounds_played increments, wrapping 255→0.
  - Next state: BROKE if the new balance = 0, else HOLD.
- HOLD: stay until start = 0, then go to IDLE. This prevents one press from starting several rounds.
- BROKE: terminal; bankrupt = 1 and start is ignored. Only resetb exits.

## Timing
- All outputs are registered or decoded from the state flop; none combinationally depend on inputs.
- Cycle n: INIT/IDLE samples start with a valid bet.
- Cycle n+1: CLEAR, game_resetb = 0.
- Cycle n+2: PLAY, game_resetb = 1.
- The game engine asserts its lights no later than 6 cycles into PLAY, so TIMEOUT = 15 leaves margin.
- Balance, result and rounds_played update at the clock edge that ends SETTLE, one cycle after the lights are first seen.
- resetb low at any time (including mid-PLAY or SETTLE) asynchronously forces all reset values. game_resetb drops immediately, so the engine is held reset too.

## Structure
- Shared package baccarat_pkg holds:
  - state encodings for this block
  - bet_side codes (BET_PLAYER, BET_DEALER, BET_TIE)
  - result codes (RES_NONE, RES_PLAYER, RES_DEALER, RES_TIE)
- The state register uses the codebase's parameterised dff with async active-low reset.
- One sub-module, bet_settle: combinational {side, amount, lights, balance} → saturated next balance.

## Test plan
- Default parameters, player bet 100, engine lights 10 on the 5th PLAY cycle → one CLEAR cycle with game_resetb = 0; balance 1000→1100, rounds_played 1, result 10, then HOLD until start drops.
- Tie bet 50, lights 11 → balance 1000→1400. Dealer bet 50, lights 11 → balance unchanged, result 11.
- Bet amount 1001 with balance 1000, or bet_side 00 → bet_err pulses, no CLEAR, game_resetb stays at its prior value.
- Dealer bet 1000, lights 10 → balance 0, BROKE, bankrupt = 1; a further start is ignored.
- Lights held 00 → fault set exactly 15 cycles after PLAY entry, balance 1000 unchanged, result 00; the next valid bet clears fault.
- INIT_BALANCE 4000, tie bet 100, lights 11 → balance saturates at 4095. Then assert resetb low mid-PLAY → all outputs return to reset values asynchronously.
